// File: rtl/ch0re_lsu.sv
// ch0re load/store unit: one aligned doubleword request per access,
// lane extraction and extension of load data for writeback.
module ch0re_lsu #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_rd,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [7:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_st_done,
    output logic            o_exc_misaligned,
    output logic [XLEN-1:0] o_exc_addr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t          state, state_n;
    logic [3:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [7:0]      be_q;
    logic            accept;
    logic            misaligned;
    logic [7:0]      be_n;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_data;
    logic            sx;

    assign o_ready     = (state == IDLE);
    assign accept      = i_valid & o_ready;
    assign o_mem_req   = (state == REQ);
    assign o_mem_we    = (state == REQ) & op_q[3];
    assign o_mem_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;

    always_comb begin
        misaligned = 1'b0;
        be_n       = 8'hFF;
        unique case (i_op[1:0])
            2'd0: begin
                misaligned = 1'b0;
                be_n       = 8'h01 << i_addr[2:0];
            end
            2'd1: begin
                misaligned = i_addr[0];
                be_n       = 8'h03 << i_addr[2:0];
            end
            2'd2: begin
                misaligned = |i_addr[1:0];
                be_n       = 8'h0F << i_addr[2:0];
            end
            2'd3: begin
                misaligned = |i_addr[2:0];
                be_n       = 8'hFF;
            end
        endcase
    end

    // Load lane is right-aligned first, then extended by size.
    assign lane = i_mem_rdata >> {addr_q[2:0], 3'b000};
    assign sx   = ~op_q[2];

    always_comb begin
        ld_data = lane;
        unique case (op_q[1:0])
            2'd0: ld_data = {{56{sx & lane[7]}}, lane[7:0]};
            2'd1: ld_data = {{48{sx & lane[15]}}, lane[15:0]};
            2'd2: ld_data = {{32{sx & lane[31]}}, lane[31:0]};
            2'd3: ld_data = lane;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept && !misaligned) state_n = REQ;
            end
            REQ: begin
                if (i_mem_gnt) state_n = op_q[3] ? IDLE : WAIT_R;
            end
            WAIT_R: begin
                if (i_mem_rvalid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q             <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            rd_q             <= '0;
            be_q             <= '0;
            o_wb_valid       <= 1'b0;
            o_wb_rd          <= '0;
            o_wb_data        <= '0;
            o_st_done        <= 1'b0;
            o_exc_misaligned <= 1'b0;
            o_exc_addr       <= '0;
        end else begin
            o_wb_valid       <= 1'b0;
            o_st_done        <= 1'b0;
            o_exc_misaligned <= 1'b0;
            if (accept) begin
                if (misaligned) begin
                    o_exc_misaligned <= 1'b1;
                    o_exc_addr       <= i_addr;
                end else begin
                    op_q    <= i_op;
                    addr_q  <= i_addr;
                    wdata_q <= i_wdata << {i_addr[2:0], 3'b000};
                    rd_q    <= i_rd;
                    be_q    <= be_n;
                end
            end
            if (state == REQ && i_mem_gnt && op_q[3])
                o_st_done <= 1'b1;
            if (state == WAIT_R && i_mem_rvalid) begin
                o_wb_valid <= 1'b1;
                o_wb_data  <= ld_data;
                o_wb_rd    <= rd_q;
            end
        end
    end
endmodule

// File: doc/ch0re_lsu.md
Name: ch0re_lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the execute-stage ALU.
- Takes the effective address produced by the ALU (ALU_ADD result), the store data (rs2) and a memory op from the EX/MEM boundary.
- Issues one aligned 64-bit request on a req/gnt/rvalid data-memory port, then returns sign- or zero-extended load data to writeback.
- Single outstanding transaction; stalls upstream via o_ready while busy.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  request valid from EX
- o_ready  output  1  LSU idle, can accept a request
- i_op  input  4  [3]=store, [2]=unsigned (loads only), [1:0]=size (0 B, 1 H, 2 W, 3 D)
- i_addr  input  64  effective address (ALU result)
- i_wdata  input  64  store data, right-aligned
- i_rd  input  5  load destination register
- o_mem_req  output  1  memory request
- o_mem_we  output  1  1=write
- o_mem_addr  output  64  doubleword-aligned address, {addr[63:3],3'b000}
- o_mem_be  output  8  byte enables
- o_mem_wdata  output  64  lane-shifted store data
- i_mem_gnt  input  1  request accepted this cycle
- i_mem_rvalid  input  1  read data valid
- i_mem_rdata  input  64  read data, full doubleword
- o_wb_valid  output  1  one-cycle pulse: load result valid
- o_wb_rd  output  5  load destination register
- o_wb_data  output  64  extended load data
- o_st_done  output  1  one-cycle pulse: store accepted by memory
- o_exc_misaligned  output  1  one-cycle pulse: misaligned access
- o_exc_addr  output  64  faulting address (held until the next exception)

Behaviour:
- Reset values:
  - state=IDLE, o_ready=1.
  - o_mem_req, o_wb_valid, o_st_done, o_exc_misaligned = 0.
  - o_wb_rd=0; o_wb_data, o_exc_addr, o_mem_addr, o_mem_be, o_mem_wdata = 0.
- FSM states: IDLE, REQ, WAIT_R. o_ready = (state==IDLE).
- Accept: at the edge where i_valid & o_ready, latch op, addr, wdata and rd.
- Alignment check at accept: misaligned when size=H & addr[0]; size=W & addr[1:0]!=0; size=D & addr[2:0]!=0.
  - Misaligned: no memory access. o_exc_misaligned=1 and o_exc_addr=addr in the next cycle. State stays IDLE.
  - Aligned: go to REQ.
- REQ state:
  - o_mem_req=1 and o_mem_we=op[3] for the whole state.
  - addr, be and wdata are driven from the latched request and held stable until i_mem_gnt.
  - On i_mem_gnt: a store goes to IDLE with o_st_done=1 in the next cycle; a load goes to WAIT_R.
  - i_mem_rvalid while in REQ is ignored.
- WAIT_R state, on i_mem_rvalid:
  - Extract the lane at byte offset addr[2:0] with the given size; sign-extend unless op[2].
  - Next cycle: o_wb_valid=1, o_wb_data=result, o_wb_rd=rd; state returns to IDLE.
  - size=D ignores op[2].
- Byte enables: B = 8'h01<<off, H = 8'h03<<off, W = 8'h0F<<off, D = 8'hFF; the same rule applies to loads.
- Store data: o_mem_wdata = i_wdata << (8*off); bytes outside be are don't-care but must be deterministic.
- o_st_done, o_wb_valid and o_exc_misaligned are single-cycle pulses and mutually exclusive.
- Minimum latency, with gnt in the first REQ cycle and rvalid on the next cycle:
  - Load: accept edge at cycle 0; o_wb_valid in cycle 3.
  - Store: o_st_done in cycle 2.
- A new request is accepted in the same cycle a pulse is visible, because the FSM is already IDLE.
- rd=0 is passed through unchanged; writeback discards it.
- i_rst mid-transaction: state goes to IDLE and o_mem_req drops the next cycle. Any later rvalid arriving in IDLE is ignored, so no o_wb_valid is produced.
- Stalls: gnt low holds REQ indefinitely; rvalid low holds WAIT_R indefinitely. No timeout.

Test Plan:
- LB, addr=0x1003, rdata=0x00000000_80FF0000 (byte3 = 0x80) -> o_mem_addr=0x1000, o_mem_be=0x08, o_wb_data=0xFFFFFFFF_FFFFFF80; LBU of the same access -> 0x80.
- LWU, addr=0x2004, rdata=0xDEADBEEF_00000000 -> o_mem_be=0xF0, o_wb_data=0x00000000_DEADBEEF; LW of the same access -> 0xFFFFFFFF_DEADBEEF.
- SH, addr=0x3006, wdata=0x1234 -> o_mem_we=1, o_mem_be=0xC0, o_mem_wdata[63:48]=0x1234; o_st_done one cycle after gnt.
- LW at addr=0x4002 -> o_exc_misaligned pulse, o_exc_addr=0x4002, o_mem_req never asserted, o_ready stays 1.
- LD with gnt held low for 5 cycles -> o_mem_req, o_mem_addr and o_mem_be stable throughout; o_ready=0 until o_wb_valid.
- i_rst asserted in WAIT_R, then rvalid pulsed -> o_mem_req=0 and o_ready=1 after reset; no o_wb_valid.
